count_access_controller: RTL and testbench
==========================================

COUNT_ACCESS_CONTROLLER -- requirements
Module: count_access_controller

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-003 SHALL have port databus, input, 8, CPU write data.
REQ-004 SHALL have port wr, input, 1, one-cycle count-register write strobe, already decoded for this counter.
REQ-005 SHALL have port rd, input, 1, one-cycle count read strobe, already decoded for this counter.
REQ-006 SHALL have port ctrl_wr, input, 1, one-cycle control-word strobe, already decoded for this counter.
REQ-007 SHALL have port ctrl_word, input, 8, 8254 control word: [7:6] SC (ignored here), [5:4] RW, [3:1] M, [0] BCD.
REQ-008 SHALL have port count_value, input, 16, live counting-element value.
REQ-009 SHALL have port ce_loaded, input, 1, one-cycle pulse from the counting element: initial_count was transferred.
REQ-010 SHALL have port initial_count, output, 16, assembled count-register value.
REQ-011 SHALL have port load_pulse, output, 1, one-cycle strobe: new complete count available.
REQ-012 SHALL have port null_count, output, 1, 8254 null-count status flag.
REQ-013 SHALL have port write_in_progress, output, 1, high while the MSB of an LSB/MSB write is awaited.
REQ-014 SHALL have port mode, output, 3, stored M field.
REQ-015 SHALL have port bcd, output, 1, stored BCD bit.
REQ-016 SHALL have port dataout, output, 8, read data, combinational.

Function
REQ-017 ctrl_wr with RW!=00 SHALL store RW, M and BCD, set the write pointer and read pointer to LSB, clear the latch, and set null_count; initial_count holds.
REQ-018 ctrl_wr with RW=00 (latch command) SHALL capture count_value into a 16-bit output latch and set latched, only if latched=0; RW, M, BCD and the write FSM are unchanged.
REQ-019 Write FSM states: WLSB, WMSB; write_in_progress=1 only in WMSB.
REQ-020 RW=01, wr: initial_count <= {8'h00, databus}; FSM stays in WLSB.
REQ-021 RW=10, wr: initial_count <= {databus, 8'h00}; FSM stays in WLSB.
REQ-022 RW=11, wr in WLSB: initial_count[7:0] <= databus; go to WMSB; no load_pulse.
REQ-023 RW=11, wr in WMSB: initial_count[15:8] <= databus; go to WLSB.
REQ-024 Every completing write (REQ-020, 021, 023) SHALL update initial_count at the capturing edge, assert load_pulse for exactly the following cycle, and set null_count.
REQ-025 null_count SHALL clear on ce_loaded; if set and clear coincide, set wins.
REQ-026 Read source SHALL be the output latch if latched=1, else count_value.
REQ-027 dataout SHALL be: source[7:0] for RW=01; source[15:8] for RW=10; for RW=11, source[7:0] when the read pointer is LSB, else source[15:8].
REQ-028 For RW=11, rd SHALL toggle the read pointer; for RW=01/10, the pointer stays LSB.
REQ-029 latched SHALL clear on the rd that completes the access: any rd for RW=01/10, or the MSB rd for RW=11.
REQ-030 If ctrl_wr and wr occur in the same cycle, ctrl_wr SHALL take effect and wr SHALL be ignored.
REQ-031 If ctrl_wr (latch) and rd occur in the same cycle, the rd SHALL be processed against the prior latch state before the latch command.
REQ-032 rd and wr in the same cycle SHALL be processed independently.
REQ-033 A wr arriving while load_pulse is high SHALL be accepted normally; back-to-back completions SHALL give back-to-back load_pulse.

Reset
REQ-034 While reset=1: initial_count=16'h0000, RW=01, mode=3'b000, bcd=0, both FSMs at LSB, latched=0, load_pulse=0, null_count=1, write_in_progress=0.
REQ-035 Reset mid-operation (e.g., in WMSB) SHALL abandon the partial write with no load_pulse.

Verification
REQ-036 Control word 8'h30 (RW=11); wr 8'h2F, then wr 8'h01 -> write_in_progress=1 between the writes; initial_count=16'h012F; a single load_pulse in the cycle after the second wr; null_count=1 until ce_loaded.
REQ-037 Control word 8'h10 (RW=01); wr 8'h47 -> initial_count=16'h0047, load_pulse one cycle; repeat with 8'h20 (RW=10), wr 8'h47 -> 16'h4700.
REQ-038 RW=11; count_value=16'hABCD; latch command 8'h00; count_value changes to 16'h1234; rd, rd -> dataout CD then AB; the third rd -> 34 (live value); a second latch before the first rd is ignored.
REQ-039 RW=11; wr 8'h55; assert ctrl_wr 8'h30 with wr 8'h66 in the same cycle -> wr ignored, FSM in WLSB, no load_pulse, initial_count[7:0]=8'h55.
REQ-040 RW=11; wr 8'h11; pulse reset -> all outputs at REQ-034 values; subsequent wr 8'h22, wr 8'h33 with RW=01 -> initial_count=16'h0033.

Source files
------------

// File: rtl/count_access_controller.sv
// 8254-style count register / status access path for a single counter:
// control-word decode, LSB/MSB count writes, count latch and read-back muxing.
module count_access_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  databus,
    input  logic        wr,
    input  logic        rd,
    input  logic        ctrl_wr,
    input  logic [7:0]  ctrl_word,
    input  logic [15:0] count_value,
    input  logic        ce_loaded,
    output logic [15:0] initial_count,
    output logic        load_pulse,
    output logic        null_count,
    output logic        write_in_progress,
    output logic [2:0]  mode,
    output logic        bcd,
    output logic [7:0]  dataout
);

    typedef enum logic {WLSB, WMSB} wstate_t;
    typedef enum logic {RLSB, RMSB} rptr_t;

    wstate_t     r_wstate;
    wstate_t     w_wstate_next;
    rptr_t       r_rptr;
    rptr_t       w_rptr_next;

    logic [1:0]  r_rw;
    logic [2:0]  r_mode;
    logic        r_bcd;
    logic [15:0] r_latch;
    logic        r_latched;
    logic [15:0] r_initial_count;
    logic        r_load_pulse;
    logic        r_null_count;

    logic        w_ctrl_prog;
    logic        w_latch_cmd;
    logic        w_rd_done;
    logic        w_complete;
    logic [15:0] w_ic_next;
    logic [15:0] w_src;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wstate <= WLSB;
            r_rptr   <= RLSB;
        end else begin
            r_wstate <= w_wstate_next;
            r_rptr   <= w_rptr_next;
        end
    end

    always_comb begin
        w_wstate_next = r_wstate;
        w_rptr_next   = r_rptr;
        w_rd_done     = 1'b0;
        w_complete    = 1'b0;
        w_ic_next     = r_initial_count;
        w_ctrl_prog   = ctrl_wr && (ctrl_word[5:4] != 2'b00);
        w_latch_cmd   = ctrl_wr && (ctrl_word[5:4] == 2'b00);

        if (rd) begin
            if (r_rw == 2'b11) begin
                w_rptr_next = (r_rptr == RLSB) ? RMSB : RLSB;
                w_rd_done   = (r_rptr == RMSB);
            end else begin
                w_rd_done   = 1'b1;
            end
        end

        // A control word pre-empts any write in the same cycle
        if (w_ctrl_prog) begin
            w_wstate_next = WLSB;
            w_rptr_next   = RLSB;
        end else if (!ctrl_wr && wr) begin
            case (r_rw)
                2'b01: begin
                    w_ic_next  = {8'h00, databus};
                    w_complete = 1'b1;
                end
                2'b10: begin
                    w_ic_next  = {databus, 8'h00};
                    w_complete = 1'b1;
                end
                2'b11: begin
                    if (r_wstate == WLSB) begin
                        w_ic_next[7:0] = databus;
                        w_wstate_next  = WMSB;
                    end else begin
                        w_ic_next[15:8] = databus;
                        w_wstate_next   = WLSB;
                        w_complete      = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rw            <= 2'b01;
            r_mode          <= '0;
            r_bcd           <= 1'b0;
            r_latch         <= '0;
            r_latched       <= 1'b0;
            r_initial_count <= '0;
            r_load_pulse    <= 1'b0;
            r_null_count    <= 1'b1;
        end else begin
            r_initial_count <= w_ic_next;
            r_load_pulse    <= w_complete;
            if (w_ctrl_prog) begin
                r_rw         <= ctrl_word[5:4];
                r_mode       <= ctrl_word[3:1];
                r_bcd        <= ctrl_word[0];
                r_latched    <= 1'b0;
                r_null_count <= 1'b1;
            end else begin
                if (w_complete) begin
                    r_null_count <= 1'b1;
                end else if (ce_loaded) begin
                    r_null_count <= 1'b0;
                end
                // A read finishing this cycle frees the latch before the latch command is considered
                if (w_latch_cmd && (!r_latched || w_rd_done)) begin
                    r_latch   <= count_value;
                    r_latched <= 1'b1;
                end else if (w_rd_done) begin
                    r_latched <= 1'b0;
                end
            end
        end
    end

    assign w_src = r_latched ? r_latch : count_value;

    always_comb begin
        dataout = w_src[7:0];
        case (r_rw)
            2'b10:   dataout = w_src[15:8];
            2'b11:   dataout = (r_rptr == RMSB) ? w_src[15:8] : w_src[7:0];
            default: dataout = w_src[7:0];
        endcase
    end

    assign initial_count     = r_initial_count;
    assign load_pulse        = r_load_pulse;
    assign null_count        = r_null_count;
    assign write_in_progress = (r_wstate == WMSB);
    assign mode              = r_mode;
    assign bcd               = r_bcd;

endmodule

// File: tb/tb_count_access_controller.sv
// Directed scenarios then randomized traffic against a transaction-level model of the counter access path.
module tb_count_access_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  databus;
    logic        wr;
    logic        rd;
    logic        ctrl_wr;
    logic [7:0]  ctrl_word;
    logic [15:0] count_value;
    logic        ce_loaded;
    logic [15:0] initial_count;
    logic        load_pulse;
    logic        null_count;
    logic        write_in_progress;
    logic [2:0]  mode;
    logic        bcd;
    logic [7:0]  dataout;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model: access mode, pending-MSB flag, byte-read index, latched snapshot
    int          m_access;
    logic [2:0]  m_mode;
    logic        m_bcd;
    bit          m_msb_pending;
    int          m_bytes_read;
    bit          m_has_snap;
    logic [15:0] m_snap;
    logic [15:0] m_count;
    bit          m_load;
    bit          m_null;

    logic [7:0]  obs;

    count_access_controller dut (
        .clk               (clk),
        .reset             (reset),
        .databus           (databus),
        .wr                (wr),
        .rd                (rd),
        .ctrl_wr           (ctrl_wr),
        .ctrl_word         (ctrl_word),
        .count_value       (count_value),
        .ce_loaded         (ce_loaded),
        .initial_count     (initial_count),
        .load_pulse        (load_pulse),
        .null_count        (null_count),
        .write_in_progress (write_in_progress),
        .mode              (mode),
        .bcd               (bcd),
        .dataout           (dataout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        n_tests++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_access      = 1;
        m_mode        = 3'd0;
        m_bcd         = 1'b0;
        m_msb_pending = 0;
        m_bytes_read  = 0;
        m_has_snap    = 0;
        m_snap        = 16'h0000;
        m_count       = 16'h0000;
        m_load        = 0;
        m_null        = 1;
    endtask

    function automatic logic [7:0] model_dout(input logic [15:0] cv);
        logic [15:0] v;
        v = m_has_snap ? m_snap : cv;
        if (m_access == 2 || (m_access == 3 && m_bytes_read == 1))
            return v / 256;
        return v % 256;
    endfunction

    task automatic model_cycle(input bit w, input bit r, input bit c, input logic [7:0] cw,
                               input logic [7:0] db, input logic [15:0] cv, input bit ce);
        bit done_write;
        bit set_null;
        done_write = 0;
        set_null   = 0;
        if (r) begin
            if (m_access == 3) begin
                m_bytes_read = m_bytes_read + 1;
                if (m_bytes_read == 2) begin
                    m_bytes_read = 0;
                    m_has_snap   = 0;
                end
            end else begin
                m_has_snap = 0;
            end
        end
        if (c) begin
            if (cw[5:4] != 2'b00) begin
                m_access      = int'(cw[5:4]);
                m_mode        = cw[3:1];
                m_bcd         = cw[0];
                m_msb_pending = 0;
                m_bytes_read  = 0;
                m_has_snap    = 0;
                set_null      = 1;
            end else if (!m_has_snap) begin
                m_has_snap = 1;
                m_snap     = cv;
            end
        end else if (w) begin
            if (m_access == 1) begin
                m_count    = 16'(db);
                done_write = 1;
            end else if (m_access == 2) begin
                m_count    = 16'(db) * 16'd256;
                done_write = 1;
            end else if (!m_msb_pending) begin
                m_count       = (m_count / 256) * 256 + 16'(db);
                m_msb_pending = 1;
            end else begin
                m_count       = 16'(db) * 16'd256 + (m_count % 256);
                m_msb_pending = 0;
                done_write    = 1;
            end
        end
        m_load = done_write;
        if (done_write || set_null) m_null = 1;
        else if (ce) m_null = 0;
    endtask

    task automatic check_regs(input string ctx);
        check({ctx, ".initial_count"}, initial_count, m_count);
        check({ctx, ".load_pulse"}, 16'(load_pulse), 16'(m_load));
        check({ctx, ".null_count"}, 16'(null_count), 16'(m_null));
        check({ctx, ".write_in_progress"}, 16'(write_in_progress), 16'(m_msb_pending));
        check({ctx, ".mode"}, 16'(mode), 16'(m_mode));
        check({ctx, ".bcd"}, 16'(bcd), 16'(m_bcd));
    endtask

    // Called just after an active edge: drive, sample dataout, clock, check state
    task automatic cycle(input string ctx, input bit w, input bit r, input bit c, input logic [7:0] cw,
                         input logic [7:0] db, input logic [15:0] cv, input bit ce,
                         output logic [7:0] dout);
        wr          = w;
        rd          = r;
        ctrl_wr     = c;
        ctrl_word   = cw;
        databus     = db;
        count_value = cv;
        ce_loaded   = ce;
        #1;
        dout = dataout;
        check({ctx, ".dataout"}, 16'(dataout), 16'(model_dout(cv)));
        @(posedge clk);
        model_cycle(w, r, c, cw, db, cv, ce);
        #1;
        check_regs(ctx);
        wr        = 1'b0;
        rd        = 1'b0;
        ctrl_wr   = 1'b0;
        ce_loaded = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        wr          = 1'b0;
        rd          = 1'b0;
        ctrl_wr     = 1'b0;
        ctrl_word   = 8'h00;
        databus     = 8'h00;
        count_value = 16'h0000;
        ce_loaded   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_regs("reset");
        check("reset.dataout_rw01", 16'(dataout), 16'h0000);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // LSB then MSB write
        cycle("r036a", 0, 0, 1, 8'h30, 8'h00, 16'h0000, 0, obs);
        cycle("r036b", 1, 0, 0, 8'h00, 8'h2F, 16'h0000, 0, obs);
        check("r036.wip_between", 16'(write_in_progress), 16'h0001);
        check("r036.no_pulse_lsb", 16'(load_pulse), 16'h0000);
        cycle("r036c", 1, 0, 0, 8'h00, 8'h01, 16'h0000, 0, obs);
        check("r036.count", initial_count, 16'h012F);
        check("r036.pulse", 16'(load_pulse), 16'h0001);
        cycle("r036d", 0, 0, 0, 8'h00, 8'h00, 16'h0000, 0, obs);
        check("r036.pulse_once", 16'(load_pulse), 16'h0000);
        check("r036.null_held", 16'(null_count), 16'h0001);
        cycle("r036e", 0, 0, 0, 8'h00, 8'h00, 16'h0000, 1, obs);
        check("r036.null_clr", 16'(null_count), 16'h0000);

        // Single-byte modes
        cycle("r037a", 0, 0, 1, 8'h10, 8'h00, 16'h0000, 0, obs);
        cycle("r037b", 1, 0, 0, 8'h00, 8'h47, 16'h0000, 0, obs);
        check("r037.lsb_only", initial_count, 16'h0047);
        cycle("r037c", 0, 0, 1, 8'h20, 8'h00, 16'h0000, 0, obs);
        cycle("r037d", 1, 0, 0, 8'h00, 8'h47, 16'h0000, 0, obs);
        check("r037.msb_only", initial_count, 16'h4700);
        cycle("r037e", 1, 0, 0, 8'h00, 8'h48, 16'h0000, 1, obs);
        check("r037.b2b_pulse", 16'(load_pulse), 16'h0001);
        check("r037.set_wins", 16'(null_count), 16'h0001);

        // Latch and two-byte read-back
        cycle("r038a", 0, 0, 1, 8'h36, 8'h00, 16'hABCD, 0, obs);
        cycle("r038b", 0, 0, 1, 8'h00, 8'h00, 16'hABCD, 0, obs);
        cycle("r038c", 0, 0, 1, 8'h00, 8'h00, 16'h1234, 0, obs);
        cycle("r038d", 0, 1, 0, 8'h00, 8'h00, 16'h1234, 0, obs);
        check("r038.rd_lsb", 16'(obs), 16'h00CD);
        cycle("r038e", 0, 1, 0, 8'h00, 8'h00, 16'h1234, 0, obs);
        check("r038.rd_msb", 16'(obs), 16'h00AB);
        cycle("r038f", 0, 1, 0, 8'h00, 8'h00, 16'h1234, 0, obs);
        check("r038.rd_live", 16'(obs), 16'h0034);
        check("r038.mode", 16'(mode), 16'h0003);

        // Control word wins over a coincident write
        cycle("r039a", 0, 0, 1, 8'h30, 8'h00, 16'h0000, 0, obs);
        cycle("r039b", 1, 0, 0, 8'h00, 8'h55, 16'h0000, 0, obs);
        cycle("r039c", 1, 0, 1, 8'h30, 8'h66, 16'h0000, 0, obs);
        check("r039.wip", 16'(write_in_progress), 16'h0000);
        check("r039.no_pulse", 16'(load_pulse), 16'h0000);
        check("r039.lsb_kept", 16'(initial_count[7:0]), 16'h0055);

        // Reset in the middle of a two-byte write
        cycle("r040a", 1, 0, 0, 8'h00, 8'h11, 16'h0000, 0, obs);
        reset = 1'b1;
        #2;
        model_reset();
        check_regs("r040.in_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("r040.no_pulse", 16'(load_pulse), 16'h0000);
        cycle("r040b", 1, 0, 0, 8'h00, 8'h22, 16'h0000, 0, obs);
        cycle("r040c", 1, 0, 0, 8'h00, 8'h33, 16'h0000, 0, obs);
        check("r040.count", initial_count, 16'h0033);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit          rw_c;
            bit          rw_w;
            bit          rw_r;
            bit          rw_ce;
            logic [7:0]  cw;
            logic [7:0]  db;
            logic [15:0] cv;
            rw_c  = ($urandom_range(0, 9) == 0);
            rw_w  = ($urandom_range(0, 9) < 4);
            rw_r  = ($urandom_range(0, 9) < 4);
            rw_ce = ($urandom_range(0, 9) < 2);
            cw    = 8'($urandom);
            db    = 8'($urandom);
            cv    = 16'($urandom);
            cycle("rand", rw_w, rw_r, rw_c, cw, db, cv, rw_ce, obs);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
